// File: rtl/axi_lite_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axi_lite_regfile_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   // Number of byte-offset bits below the register index.
   function automatic int addr_lsb(input int dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register file (slave).
interface axi_lite_regfile_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_chan_buf.sv
// One-entry valid/ready holding register; ready is simply "not full".
module axi_lite_chan_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic [W-1:0] data_o
);
   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

   // Capture on handshake, release on pop; the two never coincide since pop needs full.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (pop_i) full_d = 1'b0;
      if (valid_i && !full_q) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   // Holding register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: RW control registers, RO status registers,
// byte strobes, SLVERR decode and per-register write pulses.
module axi_lite_regfile
   import axi_lite_regfile_pkg::*;
#(
   parameter int                   DATA_WIDTH = 32,
   parameter int                   NUM_REGS   = 4,
   parameter int                   ADDR_WIDTH = $clog2(NUM_REGS) + addr_lsb(DATA_WIDTH),
   parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESET,
   axi_lite_regfile_if.slave              s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);
   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int SW       = DATA_WIDTH / 8;
   // Index field width; a single register still needs a 1-bit compare operand.
   localparam int IW       = (ADDR_WIDTH > ADDR_LSB) ? ADDR_WIDTH - ADDR_LSB : 1;

   // Write-side buffers
   logic                  aw_full, w_full, commit;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [SW+DATA_WIDTH-1:0] w_buf;
   logic [DATA_WIDTH-1:0] w_data;
   logic [SW-1:0]         w_strb;

   // State
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   pulse_q, pulse_d;
   logic                  bvalid_q, bvalid_d;
   resp_t                 bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_t                 rresp_q, rresp_d;

   logic [IW-1:0]         w_idx, r_idx;
   logic                  w_hit;

   // Protection bits carry no meaning for this bank.
   logic unused_ok;
   assign unused_ok = ^{s_axi.awprot, s_axi.arprot};

   axi_lite_chan_buf #(.W(ADDR_WIDTH)) u_aw_buf (
      .clk     (S_AXI_ACLK),
      .rst     (S_AXI_ARESET),
      .valid_i (s_axi.awvalid),
      .ready_o (s_axi.awready),
      .data_i  (s_axi.awaddr),
      .pop_i   (commit),
      .full_o  (aw_full),
      .data_o  (aw_addr)
   );

   axi_lite_chan_buf #(.W(SW + DATA_WIDTH)) u_w_buf (
      .clk     (S_AXI_ACLK),
      .rst     (S_AXI_ARESET),
      .valid_i (s_axi.wvalid),
      .ready_o (s_axi.wready),
      .data_i  ({s_axi.wstrb, s_axi.wdata}),
      .pop_i   (commit),
      .full_o  (w_full),
      .data_o  (w_buf)
   );

   assign w_data = w_buf[DATA_WIDTH-1:0];
   assign w_strb = w_buf[SW+DATA_WIDTH-1:DATA_WIDTH];

   // A write retires only once both halves are in and the previous B has been taken.
   assign commit = aw_full && w_full && !bvalid_q;

   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = !rvalid_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign wr_pulse_o    = pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
      assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
   end

   // Commit decode: byte-strobed register update, pulse and B response.
   always_comb begin
      regs_d   = regs_q;
      pulse_d  = '0;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      w_hit    = 1'b0;
      w_idx    = IW'(aw_addr >> ADDR_LSB);
      if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == IW'(i) && !RO_MASK[i]) w_hit = 1'b1;
      end
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = w_hit ? RESP_OKAY : RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hit && w_idx == IW'(i)) begin
               pulse_d[i] = 1'b1;
               for (int k = 0; k < SW; k++) begin
                  if (w_strb[k]) regs_d[i][k*8 +: 8] = w_data[k*8 +: 8];
               end
            end
         end
      end
   end

   // Read decode: registered value (pre-write on a same-cycle commit) or sampled status.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      r_idx    = IW'(s_axi.araddr >> ADDR_LSB);
      if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
      if (s_axi.arvalid && !rvalid_q) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IW'(i)) begin
               rresp_d = RESP_OKAY;
               rdata_d = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
         end
      end
   end

   // Register bank and response flops.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         pulse_q  <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         regs_q   <= regs_d;
         pulse_q  <= pulse_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench: two register files (all-RW and reg 2 read-only) share one stimulus
// driver; sel routes valids/readies to one DUT and muxes its outputs back.
module tb_axi_lite_regfile;
   import axi_lite_regfile_pkg::*;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int AW = 8;
   localparam logic [DW-1:0] RV = 32'h5A5A_A5A5;
   localparam logic [1:0] OK = 2'b00;
   localparam logic [1:0] SE = 2'b10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          sel = 1'b0;
   logic [AW-1:0] m_awaddr = '0, m_araddr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [3:0]    m_wstrb = '0;
   logic          m_awvalid = 0, m_wvalid = 0, m_bready = 0, m_arvalid = 0, m_rready = 0;

   logic [NR*DW-1:0] ctrl_a, ctrl_b, s_ctrl;
   logic [NR-1:0]    pulse_a, pulse_b, s_pulse;
   logic [NR*DW-1:0] status_a, status_b;
   assign status_a = {32'hFFFF_FFF3, 32'hFFFF_FFF2, 32'hFFFF_FFF1, 32'hFFFF_FFF0};
   assign status_b = {32'h0BAD_0003, 32'hDEAD_BEEF, 32'h0BAD_0001, 32'h0BAD_0000};

   axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
   axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

   assign if_a.awaddr = m_awaddr;  assign if_b.awaddr = m_awaddr;
   assign if_a.awprot = 3'b000;    assign if_b.awprot = 3'b000;
   assign if_a.wdata  = m_wdata;   assign if_b.wdata  = m_wdata;
   assign if_a.wstrb  = m_wstrb;   assign if_b.wstrb  = m_wstrb;
   assign if_a.araddr = m_araddr;  assign if_b.araddr = m_araddr;
   assign if_a.arprot = 3'b000;    assign if_b.arprot = 3'b000;
   assign if_a.awvalid = m_awvalid & ~sel;  assign if_b.awvalid = m_awvalid & sel;
   assign if_a.wvalid  = m_wvalid  & ~sel;  assign if_b.wvalid  = m_wvalid  & sel;
   assign if_a.bready  = m_bready  & ~sel;  assign if_b.bready  = m_bready  & sel;
   assign if_a.arvalid = m_arvalid & ~sel;  assign if_b.arvalid = m_arvalid & sel;
   assign if_a.rready  = m_rready  & ~sel;  assign if_b.rready  = m_rready  & sel;

   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;
   logic [DW-1:0] s_rdata;
   assign s_awready = sel ? if_b.awready : if_a.awready;
   assign s_wready  = sel ? if_b.wready  : if_a.wready;
   assign s_bvalid  = sel ? if_b.bvalid  : if_a.bvalid;
   assign s_bresp   = sel ? if_b.bresp   : if_a.bresp;
   assign s_arready = sel ? if_b.arready : if_a.arready;
   assign s_rvalid  = sel ? if_b.rvalid  : if_a.rvalid;
   assign s_rdata   = sel ? if_b.rdata   : if_a.rdata;
   assign s_rresp   = sel ? if_b.rresp   : if_a.rresp;
   assign s_pulse   = sel ? pulse_b      : pulse_a;
   assign s_ctrl    = sel ? ctrl_b       : ctrl_a;

   axi_lite_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                      .RO_MASK(4'b0000), .RESET_VAL(RV)) u_dut_a (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(if_a.slave),
      .ctrl_o(ctrl_a), .status_i(status_a), .wr_pulse_o(pulse_a));

   axi_lite_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                      .RO_MASK(4'b0100), .RESET_VAL(RV)) u_dut_b (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(if_b.slave),
      .ctrl_o(ctrl_b), .status_i(status_b), .wr_pulse_o(pulse_b));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [AW-1:0] a, output bit ok);
      bit hs = 0;
      m_awaddr = a; m_awvalid = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
         hs = s_awready;
         tick();
      end
      m_awvalid = 1'b0;
      ok = hs;
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s, output bit ok);
      bit hs = 0;
      m_wdata = d; m_wstrb = s; m_wvalid = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
         hs = s_wready;
         tick();
      end
      m_wvalid = 1'b0;
      ok = hs;
   endtask

   // Waits for B with BREADY high; pls is the pulse seen alongside BVALID, pa one cycle later.
   task automatic wait_b(output logic [1:0] resp, output logic [NR-1:0] pls,
                         output logic [NR-1:0] pa, output bit got);
      got = 0; resp = 2'b11; pls = '0;
      m_bready = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         if (s_bvalid) begin got = 1; resp = s_bresp; pls = s_pulse; end
         tick();
      end
      m_bready = 1'b0;
      pa = s_pulse;
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [NR-1:0] pls,
                            output logic [NR-1:0] pa);
      bit aw_done = 0, w_done = 0, hs_aw, hs_w, got;
      m_awaddr = a; m_wdata = d; m_wstrb = s;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         hs_aw = m_awvalid && s_awready;
         hs_w  = m_wvalid && s_wready;
         tick();
         if (hs_aw) begin m_awvalid = 1'b0; aw_done = 1; end
         if (hs_w)  begin m_wvalid  = 1'b0; w_done  = 1; end
      end
      m_awvalid = 1'b0; m_wvalid = 1'b0;
      chk("wr_accept", {aw_done, w_done}, 2'b11);
      wait_b(resp, pls, pa, got);
      chk("b_arrive", got, 1'b1);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
      bit hs = 0, got = 0;
      d = '1; resp = 2'b11;
      m_araddr = a; m_arvalid = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
         hs = s_arready;
         tick();
      end
      m_arvalid = 1'b0;
      chk("ar_accept", hs, 1'b1);
      m_rready = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         if (s_rvalid) begin got = 1; d = s_rdata; resp = s_rresp; end
         tick();
      end
      m_rready = 1'b0;
      chk("r_arrive", got, 1'b1);
   endtask

   typedef struct packed {
      logic          sel;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    strb;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
      logic [NR-1:0] pulse;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic s, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] st, input logic [1:0] r, input logic [DW-1:0] rd,
                      input logic [NR-1:0] p);
      vec_t v;
      v.sel = s; v.wr = w; v.addr = a; v.data = d; v.strb = st;
      v.resp = r; v.rdata = rd; v.pulse = p;
      vt.push_back(v);
   endtask

   initial begin
      logic [1:0]    resp;
      logic [NR-1:0] pls, pa;
      logic [DW-1:0] rd;
      bit            ok, got;

      // sel wr addr data strb resp rdata pulse
      add(0, 0, 8'h00, 0, 0, OK, RV, 0);
      add(0, 1, 8'h00, 32'h1, 4'hF, OK, 0, 4'b0001);
      add(0, 1, 8'h04, 32'h2, 4'hF, OK, 0, 4'b0010);
      add(0, 1, 8'h08, 32'h3, 4'hF, OK, 0, 4'b0100);
      add(0, 1, 8'h0C, 32'h4, 4'hF, OK, 0, 4'b1000);
      add(0, 0, 8'h00, 0, 0, OK, 32'h1, 0);
      add(0, 0, 8'h04, 0, 0, OK, 32'h2, 0);
      add(0, 0, 8'h08, 0, 0, OK, 32'h3, 0);
      add(0, 0, 8'h0C, 0, 0, OK, 32'h4, 0);
      add(0, 1, 8'h04, 32'hAABB_CCDD, 4'hF, OK, 0, 4'b0010);
      add(0, 1, 8'h04, 32'h1122_3344, 4'h5, OK, 0, 4'b0010);
      add(0, 0, 8'h04, 0, 0, OK, 32'hAA22_CC44, 0);
      add(0, 1, 8'h04, 32'hFFFF_FFFF, 4'h0, OK, 0, 4'b0010);
      add(0, 0, 8'h04, 0, 0, OK, 32'hAA22_CC44, 0);
      add(0, 1, 8'h10, 32'h9999_9999, 4'hF, SE, 0, 4'b0000);
      add(0, 0, 8'h10, 0, 0, SE, 32'h0, 0);
      add(0, 0, 8'h1C, 0, 0, SE, 32'h0, 0);
      add(0, 0, 8'h0E, 0, 0, OK, 32'h4, 0);
      add(1, 0, 8'h08, 0, 0, OK, 32'hDEAD_BEEF, 0);
      add(1, 1, 8'h08, 32'h1234_5678, 4'hF, SE, 0, 4'b0000);
      add(1, 0, 8'h08, 0, 0, OK, 32'hDEAD_BEEF, 0);
      add(1, 1, 8'h00, 32'hCAFE_F00D, 4'hF, OK, 0, 4'b0001);
      add(1, 0, 8'h00, 0, 0, OK, 32'hCAFE_F00D, 0);

      // Reset state
      repeat (3) tick();
      chk("rst_bvalid", {if_a.bvalid, if_b.bvalid}, 2'b00);
      chk("rst_rvalid", {if_a.rvalid, if_b.rvalid}, 2'b00);
      rst = 1'b0;
      tick();
      chk("rst_ctrl_a", ctrl_a, {4{RV}});
      chk("rst_ctrl_b", ctrl_b, {RV, 32'h0, RV, RV});
      chk("rst_outs", {if_a.bresp, if_a.rresp, if_a.rdata, pulse_a, pulse_b}, '0);
      chk("rst_ready", {if_a.awready, if_a.wready, if_a.arready}, 3'b111);

      // Table
      foreach (vt[i]) begin
         sel = vt[i].sel;
         tick();
         if (vt[i].wr) begin
            axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp, pls, pa);
            chk($sformatf("v%0d_bresp", i), resp, vt[i].resp);
            chk($sformatf("v%0d_pulse", i), pls, vt[i].pulse);
            chk($sformatf("v%0d_pulse_1cyc", i), pa, '0);
         end else begin
            axi_read(vt[i].addr, rd, resp);
            chk($sformatf("v%0d_rresp", i), resp, vt[i].resp);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
         end
      end
      chk("tbl_ctrl_a", ctrl_a, {32'h4, 32'h3, 32'hAA22_CC44, 32'h1});
      chk("tbl_ctrl_b", ctrl_b, {RV, 32'h0, RV, 32'hCAFE_F00D});

      // W ahead of AW, slow BREADY, second write stalled behind pending B
      sel = 1'b0;
      tick();
      send_w(32'h0000_1111, 4'hF, ok);
      chk("t5_w_acc", ok, 1'b1);
      chk("t5_wready_full", s_wready, 1'b0);
      repeat (3) begin
         tick();
         chk("t5_no_early_b", s_bvalid, 1'b0);
      end
      send_aw(8'h00, ok);
      chk("t5_aw_acc", ok, 1'b1);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         if (s_bvalid) got = 1; else tick();
      end
      chk("t5_b1_arrive", got, 1'b1);
      chk("t5_b1_resp", s_bresp, OK);
      chk("t5_b1_pulse", s_pulse, 4'b0001);
      m_awaddr = 8'h04; m_wdata = 32'h0000_2222; m_wstrb = 4'hF;
      m_awvalid = 1'b1; m_wvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bit ha, hw;
         ha = m_awvalid && s_awready;
         hw = m_wvalid && s_wready;
         tick();
         if (ha) m_awvalid = 1'b0;
         if (hw) m_wvalid = 1'b0;
         chk("t5_b1_held", {s_bvalid, s_bresp, s_pulse}, {1'b1, OK, 4'b0000});
      end
      chk("t5_2nd_accepted", {m_awvalid, m_wvalid}, 2'b00);
      chk("t5_2nd_stalled", s_ctrl[63:32], 32'hAA22_CC44);
      m_bready = 1'b1;
      tick();
      m_bready = 1'b0;
      chk("t5_b1_dropped", s_bvalid, 1'b0);
      wait_b(resp, pls, pa, got);
      chk("t5_b2_arrive", got, 1'b1);
      chk("t5_b2", {resp, pls, pa}, {OK, 4'b0010, 4'b0000});
      axi_read(8'h00, rd, resp);
      chk("t5_rd0", {resp, rd}, {OK, 32'h0000_1111});
      axi_read(8'h04, rd, resp);
      chk("t5_rd1", {resp, rd}, {OK, 32'h0000_2222});

      // Read landing on the commit edge of the same register returns the old value
      send_w(32'h0000_0077, 4'hF, ok);
      send_aw(8'h0C, ok);
      m_araddr = 8'h0C; m_arvalid = 1'b1;
      chk("t7_ar_ready", s_arready, 1'b1);
      tick();
      m_arvalid = 1'b0;
      chk("t7_same_edge", {s_rvalid, s_rdata, s_bvalid}, {1'b1, 32'h4, 1'b1});
      m_rready = 1'b1; m_bready = 1'b1;
      tick();
      m_rready = 1'b0; m_bready = 1'b0;
      axi_read(8'h0C, rd, resp);
      chk("t7_new_val", rd, 32'h77);

      // Reset with AW buffered and R pending
      send_aw(8'h08, ok);
      chk("t6_aw_buffered", s_awready, 1'b0);
      m_araddr = 8'h00; m_arvalid = 1'b1;
      tick();
      m_arvalid = 1'b0;
      chk("t6_r_pending", s_rvalid, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_rst_flags", {s_bvalid, s_rvalid, s_awready, s_wready}, 4'b0011);
      chk("t6_rst_regs_a", ctrl_a, {4{RV}});
      chk("t6_rst_regs_b", ctrl_b, {RV, 32'h0, RV, RV});
      tick(); tick();
      rst = 1'b0;
      m_bready = 1'b1; m_rready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t6_no_stray", {s_bvalid, s_rvalid}, 2'b00);
      end
      m_bready = 1'b0; m_rready = 1'b0;
      send_w(32'h0000_0808, 4'hF, ok);
      repeat (3) tick();
      chk("t6_w_alone_no_b", s_bvalid, 1'b0);
      send_aw(8'h08, ok);
      wait_b(resp, pls, pa, got);
      chk("t6_b_after", {got, resp, pls}, {1'b1, OK, 4'b0100});
      axi_read(8'h08, rd, resp);
      chk("t6_rd", {resp, rd}, {OK, 32'h0000_0808});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
